qpsk_ber_receiver: RTL

//  Receive end of the channel-model path: takes noisy complex samples, makes QPSK hard decisions,
//  and compares them with the transmitted bits. Transmitted bits are buffered in a FIFO.

---
 rtl/qpsk_ber_receiver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/qpsk_ber_receiver.sv
// QPSK hard-decision receiver with BER counting.
// Buffers tx bits, compares decisions, reports errors per frame.
module qpsk_ber_receiver #(
    parameter int BI         = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_SYMS = 320000,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    input  logic [1:0]       tx_bits,
    input  logic             rx_valid,
    input  logic [BI-1:0]    rx_real,
    input  logic [BI-1:0]    rx_imag,
    output logic [1:0]       rx_bits,
    output logic             rx_bits_valid,
    output logic [CNT_W-1:0] err_total,
    output logic             frame_done,
    output logic             overflow,
    output logic             underflow,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(FRAME_SYMS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REPORT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty;
    logic        push, pop;

    logic [1:0]  ref_bits;
    logic        cmp_valid;

    logic [CNT_W-1:0] err_cnt, err_base, err_nxt;
    logic [CNT_W:0]   err_sum;
    logic [1:0]       err_inc;
    logic [SW-1:0]    sym_cnt, sym_base, sym_nxt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    assign pop  = rx_valid && !empty;
    assign push = tx_valid && (!full || pop);

    assign busy = (state != IDLE);

    assign err_inc  = {1'b0, rx_bits[1] ^ ref_bits[1]} +
                      {1'b0, rx_bits[0] ^ ref_bits[0]};
    assign err_base = (state == REPORT) ? '0 : err_cnt;
    assign sym_base = (state == REPORT) ? '0 : sym_cnt;
    assign err_sum  = {1'b0, err_base} + (CNT_W+1)'(cmp_valid ? err_inc : 2'd0);
    assign err_nxt  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    assign sym_nxt  = sym_base + SW'(cmp_valid);

    // FIFO storage, written on every accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= tx_bits;
        end
    end

    // FIFO pointers and sticky flow-control flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (tx_valid && !push) overflow  <= 1'b1;
            if (rx_valid && !pop)  underflow <= 1'b1;
        end
    end

    // Decision stage: sign-bit slicing, reference bits held alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_bits       <= 2'b00;
            rx_bits_valid <= 1'b0;
            ref_bits      <= 2'b00;
            cmp_valid     <= 1'b0;
        end else begin
            rx_bits       <= {rx_real[BI-1], rx_imag[BI-1]};
            rx_bits_valid <= rx_valid;
            ref_bits      <= pop ? mem[rd_ptr[AW-1:0]] : 2'b00;
            cmp_valid     <= pop;
        end
    end

    // Error/symbol accumulation and frame report registers
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt    <= '0;
            sym_cnt    <= '0;
            err_total  <= '0;
            frame_done <= 1'b0;
        end else begin
            err_cnt    <= err_nxt;
            sym_cnt    <= sym_nxt;
            frame_done <= (state == REPORT);
            if (state == REPORT) begin
                err_total <= err_cnt;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: start on first push, report when frame fills
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (push) state_nxt = RUN;
            end
            RUN: begin
                if (cmp_valid && (sym_nxt == SW'(FRAME_SYMS)))
                    state_nxt = REPORT;
            end
            REPORT: begin
                state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
